vx_result_gather_unit: RTL

// - Receive end of the execute-side packet protocol. It collects the NUM_LANES-wide result

---
 rtl/vx_result_gather_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vx_result_gather_unit.sv
// vx_result_gather_unit: reassembles NUM_LANES-wide result packets into one THREAD_CNT-wide warp result
module vx_result_gather_unit #(
  parameter int NUM_LANES  = 4,
  parameter int THREAD_CNT = 16,
  parameter int XLEN       = 32,
  parameter int UUID_W     = 44,
  parameter int NW_W       = 4,
  parameter int NR_W       = 6,
  parameter int PID_W      = (THREAD_CNT / NUM_LANES > 1) ? $clog2(THREAD_CNT / NUM_LANES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [UUID_W-1:0]          in_uuid,
  input  logic [NW_W-1:0]            in_wid,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       in_wb,
  input  logic [NR_W-1:0]            in_rd,
  input  logic [NUM_LANES-1:0]       in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]  in_data,
  input  logic [PID_W-1:0]           in_pid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [UUID_W-1:0]          out_uuid,
  output logic [NW_W-1:0]            out_wid,
  output logic [XLEN-1:0]            out_pc,
  output logic                       out_wb,
  output logic [NR_W-1:0]            out_rd,
  output logic [THREAD_CNT-1:0]      out_tmask,
  output logic [THREAD_CNT*XLEN-1:0] out_data
);
  if (THREAD_CNT % NUM_LANES != 0) begin : g_bad_cfg
    $error("THREAD_CNT must be a multiple of NUM_LANES");
  end
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t                     state_q, state_d;
  logic [THREAD_CNT-1:0]      acc_tmask_q, acc_tmask_d, mrg_tmask;
  logic [THREAD_CNT*XLEN-1:0] acc_data_q, acc_data_d, mrg_data;
  logic [UUID_W-1:0]          acc_uuid_q, acc_uuid_d;
  logic [NW_W-1:0]            acc_wid_q, acc_wid_d;
  logic [XLEN-1:0]            acc_pc_q, acc_pc_d;
  logic                       acc_wb_q, acc_wb_d;
  logic [NR_W-1:0]            acc_rd_q, acc_rd_d;
  logic                       out_valid_q, out_valid_d;
  logic [UUID_W-1:0]          out_uuid_q, out_uuid_d;
  logic [NW_W-1:0]            out_wid_q, out_wid_d;
  logic [XLEN-1:0]            out_pc_q, out_pc_d;
  logic                       out_wb_q, out_wb_d;
  logic [NR_W-1:0]            out_rd_q, out_rd_d;
  logic [THREAD_CNT-1:0]      out_tmask_q, out_tmask_d;
  logic [THREAD_CNT*XLEN-1:0] out_data_q, out_data_d;
  logic                       fire, done;
  assign in_ready = ~in_eop | ~out_valid_q | out_ready;
  assign fire     = in_valid & in_ready;
  assign done     = fire & in_eop;
  // sop restarts the warp, so the accumulator is treated as empty before merging
  always_comb begin
    mrg_tmask = in_sop ? '0 : acc_tmask_q;
    mrg_data  = in_sop ? '0 : acc_data_q;
    for (int k = 0; k < THREAD_CNT; k++) begin
      if (in_pid == PID_W'(k / NUM_LANES)) begin
        mrg_tmask[k]             = in_tmask[k % NUM_LANES];
        mrg_data[k*XLEN +: XLEN] = in_data[(k % NUM_LANES)*XLEN +: XLEN];
      end
    end
  end
  always_comb begin
    state_d     = fire ? (in_eop ? IDLE : ACCUM) : state_q;
    acc_tmask_d = fire ? (in_eop ? '0 : mrg_tmask) : acc_tmask_q;
    acc_data_d  = fire ? (in_eop ? '0 : mrg_data) : acc_data_q;
    acc_uuid_d  = (fire & in_sop) ? in_uuid : acc_uuid_q;
    acc_wid_d   = (fire & in_sop) ? in_wid : acc_wid_q;
    acc_pc_d    = (fire & in_sop) ? in_pc : acc_pc_q;
    acc_wb_d    = (fire & in_sop) ? in_wb : acc_wb_q;
    acc_rd_d    = (fire & in_sop) ? in_rd : acc_rd_q;
    out_valid_d = done | (out_valid_q & ~out_ready);
    out_tmask_d = done ? mrg_tmask : out_tmask_q;
    out_data_d  = done ? mrg_data : out_data_q;
    out_uuid_d  = done ? (in_sop ? in_uuid : acc_uuid_q) : out_uuid_q;
    out_wid_d   = done ? (in_sop ? in_wid : acc_wid_q) : out_wid_q;
    out_pc_d    = done ? (in_sop ? in_pc : acc_pc_q) : out_pc_q;
    out_wb_d    = done ? (in_sop ? in_wb : acc_wb_q) : out_wb_q;
    out_rd_d    = done ? (in_sop ? in_rd : acc_rd_q) : out_rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_tmask_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_tmask_q <= acc_tmask_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    acc_data_q  <= acc_data_d;
    acc_uuid_q  <= acc_uuid_d;
    acc_wid_q   <= acc_wid_d;
    acc_pc_q    <= acc_pc_d;
    acc_wb_q    <= acc_wb_d;
    acc_rd_q    <= acc_rd_d;
    out_tmask_q <= out_tmask_d;
    out_data_q  <= out_data_d;
    out_uuid_q  <= out_uuid_d;
    out_wid_q   <= out_wid_d;
    out_pc_q    <= out_pc_d;
    out_wb_q    <= out_wb_d;
    out_rd_q    <= out_rd_d;
  end
  // protocol checks: warn only, since the datapath defines the recovery behaviour
  always @(posedge clk) begin
    if (!reset && fire && in_sop)
      assert (state_q == IDLE) else $warning("sop while a partial warp is held; partial warp discarded");
    if (!reset && fire && !in_sop)
      assert (state_q == ACCUM) else $warning("non-sop packet with no partial warp held");
  end
  assign out_valid = out_valid_q;
  assign out_uuid  = out_uuid_q;
  assign out_wid   = out_wid_q;
  assign out_pc    = out_pc_q;
  assign out_wb    = out_wb_q;
  assign out_rd    = out_rd_q;
  assign out_tmask = out_tmask_q;
  assign out_data  = out_data_q;
endmodule
